// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and default bus geometry for mem_bus_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 256;
  localparam int MEM_DEPTH_DEF = 14;
endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker, searching upward from rrPtr+1 among unmasked requests
module rr_arb_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lockMask,
  input  logic [$clog2(N_REQ)-1:0] rrPtr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);
  localparam int PW = $clog2(N_REQ);
  logic [N_REQ-1:0] cand;
  logic [PW-1:0] c;
  assign cand = req & lockMask;
  // walk the ring backwards so the nearest candidate after rrPtr is written last
  always_comb begin
    idx = '0;
    valid = 1'b0;
    c = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      c = PW'((int'(rrPtr) + i) % N_REQ);
      if (cand[c]) begin
        idx = c;
        valid = 1'b1;
      end
    end
  end
  assign gnt = valid ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter/sequencer for the shared memory bus; define ARB_LOCK_EN to let an owner keep the bus while Lock is high
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ-1:0]        ReqWrite,
  input  logic [N_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [N_REQ*DATA_W-1:0] ReqWData,
  input  logic [N_REQ-1:0]        Lock,
  output logic [N_REQ-1:0]        Grant,
  output logic [N_REQ-1:0]        Ack,
  output logic                    Err,
  output logic [DATA_W-1:0]       RdData,
  output logic                    Busy,
  output logic [ADDR_W-1:0]       BusAddr,
  output logic                    nRead,
  output logic                    nWrite,
  output logic [DATA_W-1:0]       BusWData,
  input  logic [DATA_W-1:0]       BusRData
);
  localparam int PW = $clog2(N_REQ);
  arb_state_t state;
  logic [2:0] cnt;
  logic [PW-1:0] rrPtr, owner, pickIdx, pickPtr;
  logic [N_REQ-1:0] ownerHot, lockMask, pickGnt;
  logic pickValid, opWrite, errQ, locked, keepLock, inRange;
  logic [ADDR_W-1:0] addrQ, pickAddr;
  logic [DATA_W-1:0] wdataQ;
`ifdef ARB_LOCK_EN
  assign keepLock = Lock[owner];
`else
  logic [N_REQ-1:0] unusedLock;
  assign unusedLock = Lock;
  assign keepLock = 1'b0;
`endif
  assign ownerHot = N_REQ'(1) << owner;
  assign pickPtr = locked ? owner : rrPtr;
  assign lockMask = locked && keepLock ? ownerHot : '1;
  assign pickAddr = ReqAddr[pickIdx*ADDR_W +: ADDR_W];
  assign inRange = pickAddr < ADDR_W'(MEM_DEPTH);
  rr_arb_pick #(.N_REQ(N_REQ)) picker (
    .req(Req),
    .lockMask(lockMask),
    .rrPtr(pickPtr),
    .gnt(pickGnt),
    .idx(pickIdx),
    .valid(pickValid)
  );
  // outputs decode straight from async-reset state so Reset releases the strobes at once
  assign Grant = state != IDLE || locked ? ownerHot : '0;
  assign Ack = state == DONE ? ownerHot : '0;
  assign Err = state == DONE && errQ;
  assign Busy = state != IDLE;
  assign nRead = !(state == ACCESS && !opWrite);
  assign nWrite = !(state == ACCESS && opWrite);
  assign BusAddr = state == ACCESS ? addrQ : '0;
  assign BusWData = state == ACCESS ? wdataQ : '0;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      rrPtr <= PW'(N_REQ - 1);
      owner <= '0;
      opWrite <= 1'b0;
      errQ <= 1'b0;
      locked <= 1'b0;
      addrQ <= '0;
      wdataQ <= '0;
      RdData <= '0;
    end else if (state == IDLE) begin
      if (locked && !keepLock) begin
        locked <= 1'b0;
        rrPtr <= owner;
      end
      if (pickValid) begin
        owner <= pickIdx;
        opWrite <= |(ReqWrite & pickGnt);
        addrQ <= pickAddr;
        wdataQ <= ReqWData[pickIdx*DATA_W +: DATA_W];
        errQ <= !inRange;
        cnt <= '0;
        state <= inRange ? ACCESS : DONE;
      end
    end else if (state == ACCESS) begin
      cnt <= cnt + 3'd1;
      if (cnt == 3'(MEM_LATENCY - 1)) begin
        state <= DONE;
        if (!opWrite) RdData <= BusRData;
      end
    end else begin
      state <= IDLE;
      locked <= keepLock;
      if (!keepLock) rrPtr <= owner;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with a small behavioural memory
module tb_mem_bus_arbiter;
  localparam int N = 2;
  localparam int AW = 16;
  localparam int DW = 256;
  localparam int DEPTH = 14;
  localparam int LAT = 2;
  logic Clk = 1'b0;
  logic Reset;
  logic [N-1:0] Req, ReqWrite, Lock, Grant, Ack;
  logic [N*AW-1:0] ReqAddr;
  logic [N*DW-1:0] ReqWData;
  logic Err, Busy, nRead, nWrite;
  logic [DW-1:0] RdData, BusWData, BusRData;
  logic [AW-1:0] BusAddr;
  logic [DW-1:0] mem [DEPTH];
  int passCnt = 0;
  int totalCnt = 0;

  mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .Lock(Lock), .Grant(Grant), .Ack(Ack), .Err(Err),
    .RdData(RdData), .Busy(Busy), .BusAddr(BusAddr), .nRead(nRead), .nWrite(nWrite),
    .BusWData(BusWData), .BusRData(BusRData)
  );

  always #5 Clk = ~Clk;
  assign BusRData = BusAddr < AW'(DEPTH) ? mem[BusAddr[3:0]] : '0;
  always @(posedge Clk) if (!nWrite && BusAddr < AW'(DEPTH)) mem[BusAddr[3:0]] <= BusWData;

  task automatic doAccess(input int m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int ackCyc, output int rdLow, output int wrLow, output int bothLow,
                          output logic [N-1:0] ackV, output logic errV);
    ReqWrite[m] = wr;
    ReqAddr[m*AW +: AW] = a;
    ReqWData[m*DW +: DW] = d;
    Req[m] = 1'b1;
    ackCyc = -1; rdLow = 0; wrLow = 0; bothLow = 0; ackV = '0; errV = 1'b0;
    for (int c = 1; c <= 20 && ackCyc < 0; c++) begin
      @(negedge Clk);
      if (!nRead) rdLow++;
      if (!nWrite) wrLow++;
      if (!nRead && !nWrite) bothLow++;
      if (Ack != '0) begin
        ackCyc = c; ackV = Ack; errV = Err; Req[m] = 1'b0;
      end
    end
    Req[m] = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = '0; ReqWrite = '0; ReqAddr = '0; ReqWData = '0; Lock = '0;
    repeat (2) @(negedge Clk);
    totalCnt++; if (Grant !== 2'b00) $display("FAIL reset_grant got %b want 00", Grant); else passCnt++;
    totalCnt++; if (Ack !== 2'b00) $display("FAIL reset_ack got %b want 00", Ack); else passCnt++;
    totalCnt++; if (Err !== 1'b0) $display("FAIL reset_err got %b want 0", Err); else passCnt++;
    totalCnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else passCnt++;
    totalCnt++; if (nRead !== 1'b1) $display("FAIL reset_nread got %b want 1", nRead); else passCnt++;
    totalCnt++; if (nWrite !== 1'b1) $display("FAIL reset_nwrite got %b want 1", nWrite); else passCnt++;
    totalCnt++; if (BusAddr !== '0) $display("FAIL reset_busaddr got %h want 0", BusAddr); else passCnt++;
    totalCnt++; if (RdData !== '0) $display("FAIL reset_rddata got %h want 0", RdData); else passCnt++;
    Reset = 1'b0;
    @(negedge Clk);
    totalCnt++; if (Busy !== 1'b0) $display("FAIL idle_busy got %b want 0", Busy); else passCnt++;
  endtask

  task automatic test_single_read();
    int ac, rl, wl, bl; logic [N-1:0] av; logic ev;
    doAccess(0, 1'b0, 16'd3, '0, ac, rl, wl, bl, av, ev);
    totalCnt++; if (ac !== 3) $display("FAIL read_latency got %0d want 3", ac); else passCnt++;
    totalCnt++; if (av !== 2'b01) $display("FAIL read_ack got %b want 01", av); else passCnt++;
    totalCnt++; if (ev !== 1'b0) $display("FAIL read_err got %b want 0", ev); else passCnt++;
    totalCnt++; if (rl !== 2) $display("FAIL read_strobe_cycles got %0d want 2", rl); else passCnt++;
    totalCnt++; if (wl !== 0) $display("FAIL read_nwrite_cycles got %0d want 0", wl); else passCnt++;
    totalCnt++; if (RdData !== DW'(6)) $display("FAIL read_data got %h want 6", RdData); else passCnt++;
    @(negedge Clk);
    totalCnt++; if (Ack !== 2'b00 || Busy !== 1'b0) $display("FAIL read_ack_pulse got ack=%b busy=%b want 00/0", Ack, Busy); else passCnt++;
  endtask

  task automatic test_single_write();
    int ac, rl, wl, bl; logic [N-1:0] av; logic ev;
    doAccess(1, 1'b1, 16'd5, DW'(8'hA5), ac, rl, wl, bl, av, ev);
    totalCnt++; if (ac !== 3) $display("FAIL write_latency got %0d want 3", ac); else passCnt++;
    totalCnt++; if (av !== 2'b10) $display("FAIL write_ack got %b want 10", av); else passCnt++;
    totalCnt++; if (wl !== 2) $display("FAIL write_strobe_cycles got %0d want 2", wl); else passCnt++;
    totalCnt++; if (rl !== 0) $display("FAIL write_nread_cycles got %0d want 0", rl); else passCnt++;
    totalCnt++; if (mem[5] !== DW'(8'hA5)) $display("FAIL write_mem got %h want a5", mem[5]); else passCnt++;
    totalCnt++; if (RdData !== DW'(6)) $display("FAIL write_rddata_kept got %h want 6", RdData); else passCnt++;
    @(negedge Clk);
  endtask

  task automatic test_contention();
    logic [N-1:0] order [4];
    logic [DW-1:0] rd [4];
    int cyc [4];
    int n = 0;
    int bl = 0;
    ReqWrite = '0;
    ReqAddr = {16'd2, 16'd1};
    Req = 2'b11;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge Clk);
      if (!nRead && !nWrite) bl++;
      if (Ack != '0) begin
        order[n] = Ack; rd[n] = RdData; cyc[n] = c; n++;
        if (n >= 3) Req = Req & ~Ack;
      end
    end
    Req = '0;
    totalCnt++; if (n !== 4) $display("FAIL cont_ack_count got %0d want 4", n); else passCnt++;
    for (int i = 0; i < n; i++) begin
      totalCnt++; if (order[i] !== (i % 2 == 0 ? 2'b01 : 2'b10)) $display("FAIL cont_order[%0d] got %b want %b", i, order[i], i % 2 == 0 ? 2'b01 : 2'b10); else passCnt++;
      totalCnt++; if (rd[i] !== DW'(i % 2 == 0 ? 2 : 4)) $display("FAIL cont_data[%0d] got %h want %0d", i, rd[i], i % 2 == 0 ? 2 : 4); else passCnt++;
      if (i > 0) begin
        totalCnt++; if (cyc[i] - cyc[i-1] !== LAT + 2) $display("FAIL cont_spacing[%0d] got %0d want %0d", i, cyc[i] - cyc[i-1], LAT + 2); else passCnt++;
      end
    end
    totalCnt++; if (bl !== 0) $display("FAIL cont_both_strobes got %0d want 0", bl); else passCnt++;
    @(negedge Clk);
  endtask

  task automatic test_out_of_range();
    int ac, rl, wl, bl; logic [N-1:0] av; logic ev;
    doAccess(0, 1'b0, 16'd14, '0, ac, rl, wl, bl, av, ev);
    totalCnt++; if (ac !== 1) $display("FAIL oor_latency got %0d want 1", ac); else passCnt++;
    totalCnt++; if (av !== 2'b01) $display("FAIL oor_ack got %b want 01", av); else passCnt++;
    totalCnt++; if (ev !== 1'b1) $display("FAIL oor_err got %b want 1", ev); else passCnt++;
    totalCnt++; if (rl + wl !== 0) $display("FAIL oor_strobes got %0d want 0", rl + wl); else passCnt++;
    totalCnt++; if (RdData !== DW'(4)) $display("FAIL oor_rddata_kept got %h want 4", RdData); else passCnt++;
    @(negedge Clk);
    totalCnt++; if (Err !== 1'b0) $display("FAIL oor_err_clear got %b want 0", Err); else passCnt++;
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    int ac = -1;
    ReqWrite = '0;
    ReqAddr = {16'd4, 16'd7};
    Req = 2'b10;
    repeat (2) @(negedge Clk);
    totalCnt++; if (nRead !== 1'b0 || Grant !== 2'b10) $display("FAIL rstmid_pre got nread=%b grant=%b want 0/10", nRead, Grant); else passCnt++;
    Reset = 1'b1;
    #1;
    totalCnt++; if (nRead !== 1'b1) $display("FAIL rstmid_nread got %b want 1", nRead); else passCnt++;
    totalCnt++; if (Grant !== 2'b00) $display("FAIL rstmid_grant got %b want 00", Grant); else passCnt++;
    totalCnt++; if (Ack !== 2'b00 || Busy !== 1'b0) $display("FAIL rstmid_ack got ack=%b busy=%b want 00/0", Ack, Busy); else passCnt++;
    Req = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (Ack != '0) acks++;
    end
    totalCnt++; if (acks !== 0) $display("FAIL rstmid_no_ack got %0d want 0", acks); else passCnt++;
    Req = 2'b11;
    for (int c = 1; c <= 20 && ac < 0; c++) begin
      @(negedge Clk);
      if (Ack != '0) ac = c;
    end
    totalCnt++; if (ac !== 3 || Ack !== 2'b01) $display("FAIL rstmid_first got cyc=%0d ack=%b want 3/01", ac, Ack); else passCnt++;
    totalCnt++; if (RdData !== DW'(14)) $display("FAIL rstmid_data0 got %h want 14", RdData); else passCnt++;
    Req[0] = 1'b0;
    ac = -1;
    for (int c = 1; c <= 20 && ac < 0; c++) begin
      @(negedge Clk);
      if (Ack != '0) ac = c;
    end
    totalCnt++; if (ac !== LAT + 2 || Ack !== 2'b10) $display("FAIL rstmid_second got cyc=%0d ack=%b want %0d/10", ac, Ack, LAT + 2); else passCnt++;
    totalCnt++; if (RdData !== DW'(8)) $display("FAIL rstmid_data1 got %h want 8", RdData); else passCnt++;
    Req = '0;
    @(negedge Clk);
  endtask

  task automatic test_lock();
    logic [N-1:0] order [3];
    logic [N-1:0] want [3];
    logic [DW-1:0] rd [3];
    logic [DW-1:0] wantRd [3];
    int n = 0;
    int k1 = 0;
`ifdef ARB_LOCK_EN
    want = '{2'b10, 2'b10, 2'b01};
    wantRd = '{DW'(4), DW'(4), DW'(0)};
`else
    want = '{2'b10, 2'b01, 2'b10};
    wantRd = '{DW'(4), DW'(0), DW'(0)};
`endif
    ReqWrite = '0;
    ReqAddr = {16'd2, 16'd0};
    Lock = 2'b10;
    Req = 2'b10;
    for (int c = 1; c <= 60 && n < 3; c++) begin
      @(negedge Clk);
      if (c == 1) Req[0] = 1'b1;
      if (Ack != '0) begin
        order[n] = Ack; rd[n] = RdData; n++;
        if (Ack[0]) Req[0] = 1'b0;
        if (Ack[1]) begin
          k1++;
          if (k1 == 1) begin
            ReqWrite[1] = 1'b1;
            ReqWData[DW +: DW] = DW'(8'h5A);
          end else begin
            Req[1] = 1'b0;
            Lock[1] = 1'b0;
          end
        end
      end
    end
    Req = '0; Lock = '0;
    totalCnt++; if (n !== 3) $display("FAIL lock_ack_count got %0d want 3", n); else passCnt++;
    for (int i = 0; i < n; i++) begin
      totalCnt++; if (order[i] !== want[i]) $display("FAIL lock_order[%0d] got %b want %b", i, order[i], want[i]); else passCnt++;
      totalCnt++; if (rd[i] !== wantRd[i]) $display("FAIL lock_data[%0d] got %h want %h", i, rd[i], wantRd[i]); else passCnt++;
    end
    totalCnt++; if (mem[2] !== DW'(8'h5A)) $display("FAIL lock_mem got %h want 5a", mem[2]); else passCnt++;
    @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(2 * i);
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    test_lock();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
